// File: rtl/controle_alarme.sv
// Alarm controller: synchronises the raw condition s1, confirms it over several
// consecutive samples, latches the alarm until acknowledged, then enforces a lockout.
// Optional alarm event counter is enabled by defining ALARME_EVT_CNT_EN.
module controle_alarme #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1,
  input  logic             ack,
  output logic             alarm,
  output logic             pending,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int CNT_MAX = (CONFIRM_CYCLES > HOLD_CYCLES) ? CONFIRM_CYCLES : HOLD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);

  // One-hot so that alarm and pending are each a single register bit, free of decode glitches.
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    CONFIRM = 4'b0010,
    ALARM   = 4'b0100,
    HOLD    = 4'b1000
  } state_t;

  localparam int CONFIRM_BIT = 1;
  localparam int ALARM_BIT   = 2;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            s1_meta, s1_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_meta <= 1'b0;
      s1_sync <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_meta <= s1;
      s1_sync <= s1_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so that every path assigns both outputs and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (s1_sync) begin
          state_nxt = CONFIRM;
          cnt_nxt   = CW'(1);
        end
      end
      CONFIRM: begin
        if (!s1_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CONFIRM_LAST) begin
          state_nxt = ALARM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ALARM: begin
        if (ack) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          if (s1_sync) begin
            state_nxt = CONFIRM;
            cnt_nxt   = CW'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    alarm   = state[ALARM_BIT];
    pending = state[CONFIRM_BIT];
  end

`ifdef ALARME_EVT_CNT_EN
  logic             enter_alarm;
  logic [CNT_W-1:0] evt_q;

  assign enter_alarm = (state != ALARM) && (state_nxt == ALARM);

  // Saturates at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (enter_alarm && (evt_q != '1)) begin
      evt_q <= evt_q + CNT_W'(1);
    end
  end

  assign event_cnt = evt_q;
`else
  assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_controle_alarme.sv
// Self-checking bench for controle_alarme: directed latency/ack/reset scenarios and
// randomized s1/ack traffic against a run-length based reference model.
module tb_controle_alarme;

  localparam int CONFIRM_CYCLES = 4;
  localparam int HOLD_CYCLES    = 8;
`ifdef ALARME_EVT_CNT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       s1;
  logic       ack;
  logic       alarm, pending;
  logic [7:0] event_cnt;
  logic       alarm_w2, pending_w2;
  logic [1:0] event_cnt_w2;

  controle_alarme #(.CONFIRM_CYCLES(CONFIRM_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s1(s1), .ack(ack),
    .alarm(alarm), .pending(pending), .event_cnt(event_cnt)
  );

  controle_alarme #(.CONFIRM_CYCLES(CONFIRM_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .ack(ack),
    .alarm(alarm_w2), .pending(pending_w2), .event_cnt(event_cnt_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: counts consecutive high synchronized samples, a lockout countdown and
  // an alarm flag; the synchronizer is a two-sample delay of the raw input.
  bit m_q1, m_q2;
  bit m_alarm;
  int m_run, m_hold_left, m_evt, m_evt_w2;

  function automatic void model_reset();
    m_q1 = 0; m_q2 = 0; m_alarm = 0;
    m_run = 0; m_hold_left = 0; m_evt = 0; m_evt_w2 = 0;
  endfunction

  function automatic void model_edge(bit s1v, bit ackv);
    bit seen;
    seen = m_q2;
    m_q2 = m_q1;
    m_q1 = s1v;
    if (m_alarm) begin
      if (ackv) begin
        m_alarm     = 0;
        m_hold_left = HOLD_CYCLES;
        m_run       = 0;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_run = seen ? 1 : 0;
    end else begin
      m_run = seen ? m_run + 1 : 0;
      if (m_run == CONFIRM_CYCLES) begin
        m_alarm = 1;
        m_run   = 0;
        if (m_evt < 255) m_evt++;
        if (m_evt_w2 < 3) m_evt_w2++;
      end
    end
  endfunction

  function automatic int exp_evt();
    return EVT_EN ? m_evt : 0;
  endfunction

  task automatic compare_all();
    bit exp_pending;
    exp_pending = (m_run > 0) && !m_alarm && (m_hold_left == 0);
    check("alarm", alarm, m_alarm);
    check("pending", pending, exp_pending);
    check("event_cnt", event_cnt, exp_evt());
    check("alarm_w2", alarm_w2, m_alarm);
    check("event_cnt_w2", event_cnt_w2, EVT_EN ? m_evt_w2 : 0);
  endtask

  // Drive inputs, take one rising edge, advance the model, compare 1 ns later.
  task automatic step(input bit s1v, input bit ackv);
    s1  = s1v;
    ack = ackv;
    @(posedge clk);
    model_edge(s1v, ackv);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b1;
    s1    = 1'b0;
    ack   = 1'b0;
    model_reset();

    // Reset state, asserted between edges.
    #2 rst_n = 1'b0;
    #1;
    check("rst_alarm", alarm, 0);
    check("rst_pending", pending, 0);
    check("rst_event_cnt", event_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);

    // Held s1: pending after edge k+2, alarm after edge k+5.
    for (int i = 0; i < 12; i++) begin
      step(1, 0);
      check("lat_pending", pending, (i >= 2 && i < 5));
      check("lat_alarm", alarm, (i >= 5));
    end
    check("lat_evt", event_cnt, EVT_EN ? 1 : 0);

    // Ack with s1 held: 8 lockout cycles, reconfirm, alarm again.
    step(1, 1);
    check("ack_alarm_off", alarm, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0);
      check("rearm_alarm", alarm, (i >= 11));
      check("rearm_pending", pending, (i >= 8 && i <= 10));
    end
    check("rearm_evt", event_cnt, EVT_EN ? 2 : 0);

    // Drop s1 while alarmed: alarm stays latched until ack, then lockout, then idle.
    for (int i = 0; i < 5; i++) begin
      step(0, 0);
      check("latched_alarm", alarm, 1);
    end
    step(0, 1);
    for (int i = 0; i < 12; i++) step(0, 0);
    check("idle_after_hold", pending | alarm, 0);

    // Ack pulses in idle do nothing; short s1 burst only pulses pending.
    step(0, 1);
    step(0, 1);
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 0; i < 6; i++) step(0, 0);
    check("short_evt", event_cnt, EVT_EN ? 2 : 0);

    // Asynchronous reset mid-alarm, with s1 still high at reset time.
    for (int i = 0; i < 7; i++) step(1, 0);
    check("pre_rst_alarm", alarm, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_alarm", alarm, 0);
    check("async_pending", pending, 0);
    check("async_evt", event_cnt, 0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0);
    check("post_rst_idle", pending | alarm, 0);

    // Randomized traffic: s1 toggles occasionally to create long runs, sporadic ack.
    begin
      bit s1_r;
      s1_r = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) s1_r = ~s1_r;
        step(s1_r, ($urandom_range(0, 5) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
